// File: rtl/tpu_host_seq_pkg.sv
// Shared definitions for the TPU host sequencer.
//   - Accelerator address map constants (A row, B push, C word, matmul start).
//   - hseq_state_t: sequencer job phases.
//   - wait_cycles(): compute window length for a given array dimension.
package tpu_pkg;

  localparam logic [15:0] A_BASE  = 16'h0100;
  localparam logic [15:0] B_BASE  = 16'h0200;
  localparam logic [15:0] C_BASE  = 16'h0300;
  localparam logic [15:0] GO_ADDR = 16'h0400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_GO,
    S_WAIT,
    S_READ,
    S_DONE
  } hseq_state_t;

  // Systolic pipeline latency: the first C read may follow the start
  // command by this many cycles.
  function automatic int wait_cycles(input int dim);
    return 3 * dim - 1;
  endfunction

endpackage

// File: rtl/tpu_host_seq_if.sv
// Memory-mapped accelerator port.
//   master: bus initiator (drives tpu_r_w, tpu_addr, tpu_dataIn; reads tpu_dataOut)
//   slave : accelerator   (returns tpu_dataOut combinationally from tpu_addr)
interface tpu_host_seq_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_dataIn;
  logic [DATAW-1:0] tpu_dataOut;

  modport master (
    output tpu_r_w,
    output tpu_addr,
    output tpu_dataIn,
    input  tpu_dataOut
  );

  modport slave (
    input  tpu_r_w,
    input  tpu_addr,
    input  tpu_dataIn,
    output tpu_dataOut
  );
endinterface

// File: rtl/tpu_host_seq.sv
// TPU host sequencer: runs one complete matrix-multiply job on the
// accelerator per accepted start.
//   LOAD  : stream A rows then B rows from the source RAM into the accelerator
//   CLEAR : zero all C accumulator words
//   GO    : issue the matmul command
//   WAIT  : let the compute window elapse with the bus idle
//   READ  : read each C half-row and write it to the destination RAM
//   DONE  : one-cycle completion pulse
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               job request (only seen in IDLE)
//   src_base, dst_base  first source / destination word (latched at accept)
//   busy, done          job status
//   src_rd/src_addr/src_data          source RAM read port (1-cycle latency)
//   dst_wr/dst_addr/dst_data          destination RAM write port
//   tpu                 accelerator bus (master side)
module tpu_host_seq
  import tpu_pkg::*;
#(
  parameter int DIM    = 8,
  parameter int ADDRW  = 16,
  parameter int DATAW  = 64,
  parameter int SADDRW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SADDRW-1:0] src_base,
  input  logic [SADDRW-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [SADDRW-1:0] src_addr,
  input  logic [DATAW-1:0]  src_data,
  output logic              dst_wr,
  output logic [SADDRW-1:0] dst_addr,
  output logic [DATAW-1:0]  dst_data,
  tpu_host_seq_if.master    tpu
);

  localparam int CW        = $clog2(3 * DIM);
  localparam int LOAD_LEN  = 2 * DIM + 1;  // one extra cycle for the read latency
  localparam int CLEAR_LEN = 2 * DIM;
  localparam int WAIT_LEN  = wait_cycles(DIM);
  localparam int READ_LEN  = 2 * DIM;

  hseq_state_t       state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [SADDRW-1:0] src_base_reg, dst_base_reg;
  logic [CW-1:0]     word_idx;

  function automatic logic [ADDRW-1:0] word_addr(input logic [15:0] base,
                                                 input logic [CW-1:0] idx);
    return ADDRW'(base) + (ADDRW'(idx) << 3);
  endfunction

  // State, phase counter and job bases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      src_base_reg <= '0;
      dst_base_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_IDLE && start) begin
        src_base_reg <= src_base;
        dst_base_reg <= dst_base;
      end
    end
  end

  // Next state; the counter restarts from zero on every phase change.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    unique case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (cnt_reg == CW'(LOAD_LEN - 1))  state_next = S_CLEAR;
      S_CLEAR: if (cnt_reg == CW'(CLEAR_LEN - 1)) state_next = S_GO;
      S_GO:    state_next = S_WAIT;
      S_WAIT:  if (cnt_reg == CW'(WAIT_LEN - 1))  state_next = S_READ;
      S_READ:  if (cnt_reg == CW'(READ_LEN - 1))  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_next != state_reg || state_reg == S_IDLE) cnt_next = '0;
  end

  // Outputs decoded from state and counter only (plus the two data pass-throughs).
  always_comb begin
    busy            = (state_reg != S_IDLE);
    done            = (state_reg == S_DONE);
    src_rd          = 1'b0;
    src_addr        = '0;
    dst_wr          = 1'b0;
    dst_addr        = '0;
    dst_data        = '0;
    tpu.tpu_r_w     = 1'b0;
    tpu.tpu_addr    = '0;
    tpu.tpu_dataIn  = '0;
    word_idx        = '0;
    unique case (state_reg)
      S_LOAD: begin
        if (cnt_reg < CW'(2 * DIM)) begin
          src_rd   = 1'b1;
          src_addr = src_base_reg + SADDRW'(cnt_reg);
        end
        // Word read in cycle k arrives in cycle k+1 and is written straight through.
        if (cnt_reg != '0) begin
          word_idx       = cnt_reg - 1'b1;
          tpu.tpu_r_w    = 1'b1;
          tpu.tpu_dataIn = src_data;
          tpu.tpu_addr   = (word_idx < CW'(DIM)) ? word_addr(A_BASE, word_idx)
                                                 : ADDRW'(B_BASE);
        end
      end
      S_CLEAR: begin
        tpu.tpu_r_w  = 1'b1;
        tpu.tpu_addr = word_addr(C_BASE, cnt_reg);
      end
      S_GO: begin
        tpu.tpu_r_w  = 1'b1;
        tpu.tpu_addr = ADDRW'(GO_ADDR);
      end
      S_READ: begin
        tpu.tpu_addr = word_addr(C_BASE, cnt_reg);
        dst_wr       = 1'b1;
        dst_addr     = dst_base_reg + SADDRW'(cnt_reg);
        dst_data     = tpu.tpu_dataOut;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
`timescale 1ns/1ps
module tb_tpu_host_seq;
  import tpu_pkg::*;

  localparam int SADDRW = 10;
  localparam int ADDRW  = 16;
  localparam int DATAW  = 64;
  localparam int SBW    = SADDRW + DATAW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Per-instance signals: index 0 is DIM=8, index 1 is DIM=4.
  logic [1:0]              start_v;
  logic [1:0][SADDRW-1:0]  src_base_v, dst_base_v, src_addr_v, dst_addr_v;
  logic [1:0]              busy_v, done_v, src_rd_v, dst_wr_v, rw_v;
  logic [1:0][ADDRW-1:0]   taddr_v;
  logic [1:0][DATAW-1:0]   tdin_v, dst_data_v;
  logic [1:0][31:0]        go_cnt_v, bad_wr_v, dst_cnt_v;

  logic [DATAW-1:0] src_mem [2][1024];
  logic [SBW-1:0]   sb_q0[$];
  logic [SBW-1:0]   sb_q1[$];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic tb_check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input int inst, input logic [SBW-1:0] v);
    if (inst == 0) sb_q0.push_back(v);
    else           sb_q1.push_back(v);
  endtask

  task automatic sb_pop(input int inst, output logic [SBW-1:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    if (inst == 0) begin
      if (sb_q0.size() > 0) begin v = sb_q0.pop_front(); ok = 1'b1; end
    end else begin
      if (sb_q1.size() > 0) begin v = sb_q1.pop_front(); ok = 1'b1; end
    end
  endtask

  function automatic int sb_size(input int inst);
    return (inst == 0) ? sb_q0.size() : sb_q1.size();
  endfunction

  // ---------------------------------------------------------------------------
  // DUT instances with source RAM, accelerator model and scoreboard consumer
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int D = (gi == 0) ? 8 : 4;

    tpu_host_seq_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

    logic              busy, done, src_rd, dst_wr;
    logic [SADDRW-1:0] src_addr, dst_addr;
    logic [DATAW-1:0]  src_q, dst_data;

    tpu_host_seq #(.DIM(D), .ADDRW(ADDRW), .DATAW(DATAW), .SADDRW(SADDRW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[gi]),
      .src_base (src_base_v[gi]),
      .dst_base (dst_base_v[gi]),
      .busy     (busy),
      .done     (done),
      .src_rd   (src_rd),
      .src_addr (src_addr),
      .src_data (src_q),
      .dst_wr   (dst_wr),
      .dst_addr (dst_addr),
      .dst_data (dst_data),
      .tpu      (bus.master)
    );

    assign busy_v[gi]     = busy;
    assign done_v[gi]     = done;
    assign src_rd_v[gi]   = src_rd;
    assign src_addr_v[gi] = src_addr;
    assign dst_wr_v[gi]   = dst_wr;
    assign dst_addr_v[gi] = dst_addr;
    assign dst_data_v[gi] = dst_data;
    assign rw_v[gi]       = bus.tpu_r_w;
    assign taddr_v[gi]    = bus.tpu_addr;
    assign tdin_v[gi]     = bus.tpu_dataIn;

    // Source RAM: registered read, data valid the cycle after src_rd.
    always @(posedge clk) if (src_rd) src_q <= src_mem[gi][src_addr];

    // Behavioural accelerator.
    logic [DATAW-1:0] a_m [8];
    logic [DATAW-1:0] b_m [8];
    logic [DATAW-1:0] c_m [16];
    int bptr = 0, go_cnt = 0, bad_wr = 0, dst_cnt = 0;
    int widx;
    assign widx        = int'(bus.tpu_addr[7:3]);
    assign go_cnt_v[gi]  = go_cnt;
    assign bad_wr_v[gi]  = bad_wr;
    assign dst_cnt_v[gi] = dst_cnt;

    initial for (int i = 0; i < 16; i++) c_m[i] = 64'hDEAD_BEEF_CAFE_F00D;

    function automatic logic [DATAW-1:0] mac(input logic [DATAW-1:0] cw, input int i, input int h);
      logic [DATAW-1:0] r;
      r = cw;
      for (int l = 0; l < 4; l++) begin
        int col;
        logic [15:0] s;
        col = 4 * h + l;
        s   = cw[16*l +: 16];
        if (col < D)
          for (int k = 0; k < D; k++)
            s = s + 16'(a_m[i][8*k +: 8]) * 16'(b_m[k][8*col +: 8]);
        r[16*l +: 16] = s;
      end
      return r;
    endfunction

    always @(posedge clk) begin
      if (!rst_n) bptr <= 0;
      else if (bus.tpu_r_w) begin
        if (bus.tpu_addr == 16'h0200) begin
          if (bptr < D) b_m[bptr] <= bus.tpu_dataIn;
          else          bad_wr <= bad_wr + 1;
          bptr <= bptr + 1;
        end else if (bus.tpu_addr == 16'h0400) begin
          go_cnt <= go_cnt + 1;
          bptr   <= 0;
          for (int i = 0; i < D; i++)
            for (int h = 0; h < 2; h++)
              c_m[2*i+h] <= mac(c_m[2*i+h], i, h);
        end else if (bus.tpu_addr[2:0] == 3'd0 && bus.tpu_addr[15:8] == 8'h01 && widx < D)
          a_m[widx] <= bus.tpu_dataIn;
        else if (bus.tpu_addr[2:0] == 3'd0 && bus.tpu_addr[15:8] == 8'h03 && widx < 2 * D)
          c_m[widx] <= bus.tpu_dataIn;
        else
          bad_wr <= bad_wr + 1;
      end
    end

    always_comb begin
      bus.tpu_dataOut = '0;
      if (bus.tpu_addr[15:8] == 8'h03 && bus.tpu_addr[2:0] == 3'd0 && widx < 2 * D)
        bus.tpu_dataOut = c_m[widx];
    end

    // Scoreboard consumer: every destination write must match the next expectation.
    always @(negedge clk) begin
      if (rst_n && dst_wr) begin
        logic [SBW-1:0] e;
        bit ok;
        sb_pop(gi, e, ok);
        dst_cnt <= dst_cnt + 1;
        tb_check($sformatf("sb%0d_avail", gi), ok, 1'b1);
        if (ok) tb_check($sformatf("sb%0d_dst@%0d", gi, dst_addr), {dst_addr, dst_data}, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and bus schedule
  // ---------------------------------------------------------------------------
  function automatic logic [DATAW-1:0] ref_word(input int inst, input int dim,
                                                input logic [SADDRW-1:0] sb, input int j);
    logic [DATAW-1:0] r, arow, brow;
    int i, h;
    r = '0;
    i = j / 2;
    h = j % 2;
    arow = src_mem[inst][sb + SADDRW'(i)];
    for (int l = 0; l < 4; l++) begin
      logic [15:0] s;
      s = '0;
      if (4 * h + l < dim) begin
        for (int k = 0; k < dim; k++) begin
          brow = src_mem[inst][sb + SADDRW'(dim + k)];
          s = s + 16'(arow[8*k +: 8]) * 16'(brow[8*(4*h+l) +: 8]);
        end
      end
      r[16*l +: 16] = s;
    end
    return r;
  endfunction

  function automatic logic [127:0] pack(input logic bz, input logic dn, input logic rd,
                                        input logic [SADDRW-1:0] sa, input logic rw,
                                        input logic [ADDRW-1:0] ta, input logic [DATAW-1:0] td,
                                        input logic wr, input logic [SADDRW-1:0] da);
    return {23'd0, bz, dn, rd, rd ? sa : 10'd0, rw, ta, td, wr, wr ? da : 10'd0};
  endfunction

  function automatic logic [127:0] act_bus(input int inst);
    return pack(busy_v[inst], done_v[inst], src_rd_v[inst], src_addr_v[inst], rw_v[inst],
                taddr_v[inst], tdin_v[inst], dst_wr_v[inst], dst_addr_v[inst]);
  endfunction

  function automatic logic [127:0] act_raw(input int inst);
    return {23'd0, busy_v[inst], done_v[inst], src_rd_v[inst], src_addr_v[inst], rw_v[inst],
            taddr_v[inst], tdin_v[inst], dst_wr_v[inst], dst_addr_v[inst]};
  endfunction

  // Expected bus picture for cycle c after the accepting edge.
  function automatic logic [127:0] exp_bus(input int inst, input int dim, input int c,
                                           input logic [SADDRW-1:0] sb, input logic [SADDRW-1:0] db);
    int l_end, cl_end, go_c, w_end, r_end;
    logic rd, rw, wr, dn;
    logic [SADDRW-1:0] sa, da;
    logic [ADDRW-1:0] ta;
    logic [DATAW-1:0] td;
    l_end  = 2 * dim + 1;
    cl_end = l_end + 2 * dim;
    go_c   = cl_end;
    w_end  = go_c + 1 + 3 * dim - 1;
    r_end  = w_end + 2 * dim;
    rd = 0; rw = 0; wr = 0; dn = 0; sa = '0; da = '0; ta = '0; td = '0;
    if (c < l_end) begin
      if (c < 2 * dim) begin rd = 1; sa = sb + SADDRW'(c); end
      if (c >= 1) begin
        rw = 1;
        td = src_mem[inst][sb + SADDRW'(c - 1)];
        ta = (c - 1 < dim) ? 16'h0100 + 16'((c - 1) * 8) : 16'h0200;
      end
    end else if (c < cl_end) begin
      rw = 1;
      ta = 16'h0300 + 16'((c - l_end) * 8);
    end else if (c == go_c) begin
      rw = 1;
      ta = 16'h0400;
    end else if (c < w_end) begin
    end else if (c < r_end) begin
      ta = 16'h0300 + 16'((c - w_end) * 8);
      wr = 1;
      da = db + SADDRW'(c - w_end);
    end else begin
      dn = 1;
    end
    return pack(1'b1, dn, rd, sa, rw, ta, td, wr, da);
  endfunction

  // ---------------------------------------------------------------------------
  // Job driver: pushes expectations, starts the job, checks every bus cycle.
  // abort_at >= 0 pulls rst_n low at that cycle instead of finishing.
  // ---------------------------------------------------------------------------
  task automatic run_job(input int inst, input logic [SADDRW-1:0] sb,
                         input logic [SADDRW-1:0] db, input int abort_at);
    int dim, len;
    logic [31:0] go0, dst0;
    dim = (inst == 0) ? 8 : 4;
    len = 9 * dim + 2;
    for (int j = 0; j < 2 * dim; j++) sb_push(inst, {db + SADDRW'(j), ref_word(inst, dim, sb, j)});
    go0  = go_cnt_v[inst];
    dst0 = dst_cnt_v[inst];
    @(negedge clk);
    tb_check($sformatf("idle_before%0d", inst), busy_v[inst], 1'b0);
    start_v[inst]    = 1'b1;
    src_base_v[inst] = sb;
    dst_base_v[inst] = db;
    @(posedge clk);
    #1 start_v[inst] = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        tb_check("rst_mid_bus", act_raw(inst), 128'd0);
        tb_check("rst_mid_dst_data", dst_data_v[inst], 64'd0);
        if (inst == 0) sb_q0.delete(); else sb_q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] job inst%0d src=%0d dst=%0d aborted at cycle %0d", inst, sb, db, c);
        return;
      end
      tb_check($sformatf("bus%0d_c%0d", inst, c), act_bus(inst), exp_bus(inst, dim, c, sb, db));
    end
    @(negedge clk);
    tb_check($sformatf("idle_after%0d", inst), busy_v[inst], 1'b0);
    tb_check($sformatf("go_once%0d", inst), go_cnt_v[inst] - go0, 32'd1);
    tb_check($sformatf("dst_words%0d", inst), dst_cnt_v[inst] - dst0, 32'(2 * dim));
    tb_check($sformatf("bad_wr%0d", inst), bad_wr_v[inst], 32'd0);
    tb_check($sformatf("sb_drained%0d", inst), sb_size(inst), 32'd0);
    $display("[TB] job inst%0d src=%0d dst=%0d complete", inst, sb, db);
  endtask

  // start held high across a job: exactly one job, then a second accepted
  // in the cycle IDLE is re-entered.
  task automatic hold_test();
    int busy_cyc, done_cnt, done_first, done_second;
    logic [31:0] go0, dst0;
    logic gap_busy, after_gap_busy;
    busy_cyc = 0; done_cnt = 0; done_first = -1; done_second = -1;
    gap_busy = 1'b1; after_gap_busy = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 16; j++) sb_push(0, {10'd100 + SADDRW'(j), ref_word(0, 8, 10'd0, j)});
    go0  = go_cnt_v[0];
    dst0 = dst_cnt_v[0];
    @(negedge clk);
    start_v[0] = 1'b1; src_base_v[0] = 10'd0; dst_base_v[0] = 10'd100;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (busy_v[0]) busy_cyc++;
      if (done_v[0]) begin
        if (done_cnt == 0) done_first = c; else done_second = c;
        done_cnt++;
      end
      if (c == 74) gap_busy = busy_v[0];
      if (c == 75) after_gap_busy = busy_v[0];
      if (c == 80) start_v[0] = 1'b0;
    end
    tb_check("hold_busy_cycles", busy_cyc, 148);
    tb_check("hold_done_count", done_cnt, 2);
    tb_check("hold_done_first", done_first, 73);
    tb_check("hold_done_second", done_second, 148);
    tb_check("hold_gap_idle", gap_busy, 1'b0);
    tb_check("hold_rearm", after_gap_busy, 1'b1);
    tb_check("hold_go_count", go_cnt_v[0] - go0, 32'd2);
    tb_check("hold_dst_words", dst_cnt_v[0] - dst0, 32'd32);
    tb_check("hold_sb_drained", sb_size(0), 32'd0);
    $display("[TB] job inst0 held-start pair complete");
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Words 0..7: identity A rows; 8..15: B row p holds p+1 in every byte;
    // everything else: word w = w*0x0101010101010101 (byte value w mod 256).
    for (int m = 0; m < 2; m++)
      for (int w = 0; w < 1024; w++) begin
        if (w < 8)       src_mem[m][w] = 64'd1 << (8 * w);
        else if (w < 16) src_mem[m][w] = 64'(w - 7) * 64'h0101_0101_0101_0101;
        else             src_mem[m][w] = 64'(w % 256) * 64'h0101_0101_0101_0101;
      end
    start_v = '0; src_base_v = '0; dst_base_v = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      tb_check($sformatf("reset_bus%0d", m), act_raw(m), 128'd0);
      tb_check($sformatf("reset_dst_data%0d", m), dst_data_v[m], 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_job(0, 10'd0,    10'd0,    -1);  // identity x (rows 1..8)
    run_job(0, 10'd32,   10'd200,  -1);  // ramp pattern
    hold_test();
    run_job(0, 10'd0,    10'd300,  40);  // reset during WAIT
    run_job(0, 10'd16,   10'd400,  -1);  // clean job after the abort
    run_job(1, 10'd1020, 10'd1020, -1);  // DIM=4, addresses wrap

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
